// File: rtl/l1_cluster_collector_pkg.sv
// l1c_pkg: shared widths, cluster word layout and FSM states
// for the L1 cluster collector (optional feature: L1C_ROWSUM_EN).
package l1c_pkg;
  localparam int NETA  = 24;
  localparam int DEPTH = 12;
  localparam int CW    = 23;
  localparam int IW    = 4;
  localparam int SW    = 13;

  localparam int PT_LSB   = 0;
  localparam int PT_MSB   = 8;
  localparam int ETA_LSB  = 9;
  localparam int ETA_MSB  = 13;
  localparam int XCNT_LSB = 14;
  localparam int XCNT_MSB = 17;
  localparam int NTRX_LSB = 18;
  localparam int NTRX_MSB = 22;

  localparam logic [IW-1:0] DEPTH_C = IW'(DEPTH);

  typedef struct packed {
    logic [NTRX_MSB-NTRX_LSB:0] ntrx;
    logic [XCNT_MSB-XCNT_LSB:0] xcount;
    logic [ETA_MSB-ETA_LSB:0]   eta;
    logic [PT_MSB-PT_LSB:0]     pt;
  } l1_cluster_t;

  typedef enum logic {
    WR_OPEN,
    WR_BLOCK
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_STREAM,
    RD_DRAIN
  } rd_state_e;

  function automatic logic [SW-1:0] pt_ext(input l1_cluster_t w);
    return {{(SW-PT_MSB-1){1'b0}}, w.pt};
  endfunction
endpackage

// File: rtl/l1_cluster_collector_if.sv
// Clusterer-side and L2-side bundle of the L1 cluster collector.
// row_pt_sum exists only when L1C_ROWSUM_EN is defined.
interface l1_cluster_collector_if;
  import l1c_pkg::*;

  logic [CW-1:0] L1_cluster_in;
  logic          L1_cluster_valid;
  logic          phi_done;
  logic          mj_ready;
  logic          rd_req;
  logic [CW-1:0] row_out;
  logic          row_valid;
  logic          row_last;
  logic          row_done;
  logic [3:0]    row_cnt;
  logic [1:0]    rows_avail;
  logic          overflow;
`ifdef L1C_ROWSUM_EN
  logic [SW-1:0] row_pt_sum;
`endif

  modport slave (
    input  L1_cluster_in, L1_cluster_valid,
    input  phi_done, rd_req,
    output mj_ready, row_out, row_valid,
    output row_last, row_done, row_cnt,
    output rows_avail, overflow
`ifdef L1C_ROWSUM_EN
    , output row_pt_sum
`endif
  );

  modport master (
    output L1_cluster_in, L1_cluster_valid,
    output phi_done, rd_req,
    input  mj_ready, row_out, row_valid,
    input  row_last, row_done, row_cnt,
    input  rows_avail, overflow
`ifdef L1C_ROWSUM_EN
    , input row_pt_sum
`endif
  );
endinterface

// File: rtl/l1_cluster_collector_bank_ram.sv
// l1c_bank_ram: two-bank cluster store, one write port and
// one registered read port, addressed by {bank, index}.
module l1c_bank_ram
  import l1c_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [IW-1:0] widx,
  input  logic [CW-1:0] wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [IW-1:0] ridx,
  output logic [CW-1:0] rdata
);
  logic [CW-1:0] mem [2][DEPTH];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[wbank][widx] <= wdata;
    if (re) rdata <= mem[rbank][ridx];
  end
endmodule

// File: rtl/l1_cluster_collector.sv
// l1_cluster_collector: ping-pong row capture and in-order replay.
// Define L1C_ROWSUM_EN to add the per-row pt sum output.
module l1_cluster_collector
  import l1c_pkg::*;
(
  input  logic clk,
  input  logic rstb,
  l1_cluster_collector_if.slave bus
);
  wr_state_e wst_q, wst_d;
  rd_state_e rds_q, rds_d;
  logic mj_q, mj_d;
  logic wb_q, rb_q, dprev_q, ovf_q;
  logic [1:0] closed_q, avail_q;
  logic [1:0][IW-1:0] cnt_q;
  logic [IW-1:0] raddr_q, len_q;
  logic p1_vld_q, p1_last_q, p1_done_q;
  logic vld_q, last_q, done_q;
  logic [CW-1:0] out_q, rdata;
  logic rise, full, wr_en, drop, close, free;
  logic start, issue, fin, other_closed;

  assign rise  = bus.phi_done & ~dprev_q;
  assign free  = done_q;
  assign full  = cnt_q[wb_q] == DEPTH_C;
  assign close = rise & (wst_q == WR_OPEN);
  assign wr_en = bus.L1_cluster_valid
               & (wst_q == WR_OPEN) & ~full;
  assign drop  = (bus.L1_cluster_valid
               & ((wst_q == WR_BLOCK) | full))
               | (rise & (wst_q == WR_BLOCK));
  assign other_closed = closed_q[~wb_q]
                      & ~(free & (rb_q == ~wb_q));

  // write FSM state and registered mj_ready
  always_ff @(posedge clk) begin
    if (!rstb) begin
      wst_q <= WR_OPEN;
      mj_q  <= 1'b0;
    end else begin
      wst_q <= wst_d;
      mj_q  <= mj_d;
    end
  end

  // write FSM next state: block when both banks are closed
  always_comb begin
    wst_d = wst_q;
    unique case (wst_q)
      WR_OPEN:
        if (close & other_closed) wst_d = WR_BLOCK;
      WR_BLOCK:
        if (free & (rb_q == wb_q)) wst_d = WR_OPEN;
      default: wst_d = WR_OPEN;
    endcase
  end

  // write FSM output
  always_comb begin
    mj_d = (wst_d == WR_OPEN);
  end

  // bank counts, closed flags, pointers and status
  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt_q    <= '0;
      closed_q <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      avail_q  <= '0;
      ovf_q    <= 1'b0;
      dprev_q  <= 1'b0;
    end else begin
      dprev_q <= bus.phi_done;
      if (wr_en) cnt_q[wb_q] <= cnt_q[wb_q] + 1'b1;
      if (close) begin
        closed_q[wb_q] <= 1'b1;
        wb_q <= ~wb_q;
      end
      if (free) begin
        closed_q[rb_q] <= 1'b0;
        cnt_q[rb_q] <= '0;
        rb_q <= ~rb_q;
      end
      if (close & ~free) avail_q <= avail_q + 1'b1;
      else if (free & ~close) avail_q <= avail_q - 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // read FSM state register
  always_ff @(posedge clk) begin
    if (!rstb) rds_q <= RD_IDLE;
    else       rds_q <= rds_d;
  end

  // read FSM next state: idle, stream beats, wait for row_done
  always_comb begin
    rds_d = rds_q;
    unique case (rds_q)
      RD_IDLE:   if (start) rds_d = RD_STREAM;
      RD_STREAM: if (fin)   rds_d = RD_DRAIN;
      RD_DRAIN:  if (free)  rds_d = RD_IDLE;
      default:   rds_d = RD_IDLE;
    endcase
  end

  // read FSM outputs: start, RAM issue, final issue
  always_comb begin
    start = (rds_q == RD_IDLE) & bus.rd_req
          & (avail_q != 2'd0);
    issue = (rds_q == RD_STREAM) & (len_q != '0);
    fin   = (rds_q == RD_STREAM)
          & (({1'b0, raddr_q} + 5'd1) >= {1'b0, len_q});
  end

  // read address, row length and two-stage output pipe
  always_ff @(posedge clk) begin
    if (!rstb) begin
      raddr_q   <= '0;
      len_q     <= '0;
      p1_vld_q  <= 1'b0;
      p1_last_q <= 1'b0;
      p1_done_q <= 1'b0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= '0;
    end else begin
      if (start) begin
        raddr_q <= '0;
        len_q   <= cnt_q[rb_q];
      end else if (issue) begin
        raddr_q <= raddr_q + 1'b1;
      end
      p1_vld_q  <= issue;
      p1_last_q <= issue & fin;
      p1_done_q <= fin;
      vld_q     <= p1_vld_q;
      last_q    <= p1_last_q;
      done_q    <= p1_done_q;
      out_q     <= p1_vld_q ? rdata : '0;
    end
  end

  l1c_bank_ram u_ram (
    .clk   (clk),
    .we    (wr_en),
    .wbank (wb_q),
    .widx  (cnt_q[wb_q]),
    .wdata (bus.L1_cluster_in),
    .re    (issue),
    .rbank (rb_q),
    .ridx  (raddr_q),
    .rdata (rdata)
  );

`ifdef L1C_ROWSUM_EN
  logic [1:0][SW-1:0] sum_q;
  logic [SW-1:0] rsum_q;

  // per-bank pt sums during fill, latched at replay start
  always_ff @(posedge clk) begin
    if (!rstb) begin
      sum_q  <= '0;
      rsum_q <= '0;
    end else begin
      if (wr_en)
        sum_q[wb_q] <= sum_q[wb_q]
                     + pt_ext(bus.L1_cluster_in);
      if (free) sum_q[rb_q] <= '0;
      if (start) rsum_q <= sum_q[rb_q];
    end
  end

  assign bus.row_pt_sum = rsum_q;
`endif

  assign bus.mj_ready   = mj_q;
  assign bus.row_out    = out_q;
  assign bus.row_valid  = vld_q;
  assign bus.row_last   = last_q;
  assign bus.row_done   = done_q;
  assign bus.row_cnt    = len_q;
  assign bus.rows_avail = avail_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_l1_cluster_collector.sv
// Directed bench for l1_cluster_collector; covers the
// row sum output when L1C_ROWSUM_EN is defined.
module tb_l1_cluster_collector;
  logic clk;
  logic rstb;
  int checks;
  int failures;
  logic [22:0] exp_w [14];

  l1_cluster_collector_if bus ();

  l1_cluster_collector dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [22:0] cw(input int nt, input int xc,
                                     input int eta, input int pt);
    return {5'(nt), 4'(xc), 5'(eta), 9'(pt)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [22:0] w);
    bus.L1_cluster_valid = 1'b1;
    bus.L1_cluster_in = w;
    tick;
    bus.L1_cluster_valid = 1'b0;
    bus.L1_cluster_in = '0;
  endtask

  task automatic close_row;
    bus.phi_done = 1'b1;
    tick;
    bus.phi_done = 1'b0;
  endtask

  task automatic expect_row(input string tag, input int n,
                            input int sum);
    bus.rd_req = 1'b1;
    tick;
    bus.rd_req = 1'b0;
    chk({tag, "_v_t0"}, 32'(bus.row_valid), 0);
    tick;
    chk({tag, "_v_t1"}, 32'(bus.row_valid), 0);
    chk({tag, "_d_t1"}, 32'(bus.row_done), 0);
    tick;
    if (n == 0) begin
      chk({tag, "_empty_done"}, 32'(bus.row_done), 1);
      chk({tag, "_empty_valid"}, 32'(bus.row_valid), 0);
      chk({tag, "_empty_last"}, 32'(bus.row_last), 0);
    end
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(bus.row_valid), 1);
      chk({tag, "_data"}, 32'(bus.row_out), 32'(exp_w[i]));
      chk({tag, "_last"}, 32'(bus.row_last), 32'(i == n - 1));
      chk({tag, "_done"}, 32'(bus.row_done), 32'(i == n - 1));
      chk({tag, "_cnt"}, 32'(bus.row_cnt), 32'(n));
`ifdef L1C_ROWSUM_EN
      chk({tag, "_sum"}, 32'(bus.row_pt_sum), 32'(sum));
`endif
      if (i < n - 1) tick;
    end
`ifdef L1C_ROWSUM_EN
    if (n == 0) chk({tag, "_empty_sum"}, 32'(bus.row_pt_sum), 32'(sum));
`endif
    tick;
    chk({tag, "_done_clr"}, 32'(bus.row_done), 0);
    chk({tag, "_valid_clr"}, 32'(bus.row_valid), 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstb = 1'b0;
    bus.L1_cluster_in = '0;
    bus.L1_cluster_valid = 1'b0;
    bus.phi_done = 1'b0;
    bus.rd_req = 1'b0;
    tick;
    tick;
    chk("rst_mj", 32'(bus.mj_ready), 0);
    chk("rst_avail", 32'(bus.rows_avail), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_valid", 32'(bus.row_valid), 0);
    chk("rst_done", 32'(bus.row_done), 0);
    rstb = 1'b1;
    tick;
    chk("rel_mj", 32'(bus.mj_ready), 1);

    // single row of three clusters
    exp_w[0] = cw(1, 1, 2, 10);
    exp_w[1] = cw(2, 3, 7, 20);
    exp_w[2] = cw(3, 5, 15, 30);
    for (int i = 0; i < 3; i++) push(exp_w[i]);
    chk("r1_avail0", 32'(bus.rows_avail), 0);
    close_row;
    chk("r1_avail", 32'(bus.rows_avail), 1);
    chk("r1_mj", 32'(bus.mj_ready), 1);
    expect_row("r1", 3, 60);
    chk("r1_avail_end", 32'(bus.rows_avail), 0);
    chk("r1_ovf", 32'(bus.overflow), 0);

    // request with nothing closed is ignored
    bus.rd_req = 1'b1;
    tick;
    bus.rd_req = 1'b0;
    tick;
    tick;
    chk("nreq_valid", 32'(bus.row_valid), 0);
    chk("nreq_done", 32'(bus.row_done), 0);
    tick;
    chk("nreq_done2", 32'(bus.row_done), 0);

    // empty row
    close_row;
    chk("empty_avail", 32'(bus.rows_avail), 1);
    expect_row("empty", 0, 0);
    chk("empty_avail_end", 32'(bus.rows_avail), 0);

    // close of row B coincides with free of row A
    exp_w[0] = cw(4, 1, 3, 100);
    exp_w[1] = cw(5, 2, 4, 200);
    push(exp_w[0]);
    push(exp_w[1]);
    close_row;
    chk("ov_availA", 32'(bus.rows_avail), 1);
    bus.rd_req = 1'b1;
    bus.L1_cluster_valid = 1'b1;
    bus.L1_cluster_in = cw(6, 1, 20, 5);
    tick;
    bus.rd_req = 1'b0;
    bus.L1_cluster_in = cw(7, 2, 21, 6);
    tick;
    bus.L1_cluster_in = cw(8, 3, 22, 7);
    tick;
    bus.L1_cluster_valid = 1'b0;
    bus.L1_cluster_in = '0;
    chk("ov_a0", 32'(bus.row_out), 32'(exp_w[0]));
    chk("ov_a0_v", 32'(bus.row_valid), 1);
    tick;
    chk("ov_a1", 32'(bus.row_out), 32'(exp_w[1]));
    chk("ov_a1_done", 32'(bus.row_done), 1);
    bus.phi_done = 1'b1;
    tick;
    bus.phi_done = 1'b0;
    chk("ov_avail_same", 32'(bus.rows_avail), 1);
    chk("ov_mj", 32'(bus.mj_ready), 1);
    chk("ov_done_clr", 32'(bus.row_done), 0);
    exp_w[0] = cw(6, 1, 20, 5);
    exp_w[1] = cw(7, 2, 21, 6);
    exp_w[2] = cw(8, 3, 22, 7);
    expect_row("rowB", 3, 18);
    chk("rowB_avail", 32'(bus.rows_avail), 0);

    // two rows closed, writer blocks
    push(cw(1, 1, 1, 11));
    push(cw(1, 1, 2, 12));
    close_row;
    chk("blk_mj1", 32'(bus.mj_ready), 1);
    push(cw(2, 2, 9, 40));
    close_row;
    chk("blk_mj0", 32'(bus.mj_ready), 0);
    chk("blk_avail2", 32'(bus.rows_avail), 2);
    chk("blk_ovf0", 32'(bus.overflow), 0);
    push(cw(3, 3, 3, 99));
    chk("blk_ovf1", 32'(bus.overflow), 1);
    chk("blk_mj_still0", 32'(bus.mj_ready), 0);
    exp_w[0] = cw(1, 1, 1, 11);
    exp_w[1] = cw(1, 1, 2, 12);
    expect_row("blkA", 2, 23);
    chk("blk_mj_rise", 32'(bus.mj_ready), 1);
    chk("blk_avail1", 32'(bus.rows_avail), 1);
    exp_w[0] = cw(2, 2, 9, 40);
    expect_row("blkB", 1, 40);
    chk("blk_avail0", 32'(bus.rows_avail), 0);

    // reset in the middle of a replay
    exp_w[0] = cw(9, 4, 10, 77);
    exp_w[1] = cw(9, 4, 11, 78);
    push(exp_w[0]);
    push(exp_w[1]);
    close_row;
    bus.rd_req = 1'b1;
    tick;
    bus.rd_req = 1'b0;
    tick;
    tick;
    chk("mid_valid", 32'(bus.row_valid), 1);
    chk("mid_data", 32'(bus.row_out), 32'(exp_w[0]));
    rstb = 1'b0;
    tick;
    chk("mrst_valid", 32'(bus.row_valid), 0);
    chk("mrst_out", 32'(bus.row_out), 0);
    chk("mrst_last", 32'(bus.row_last), 0);
    chk("mrst_done", 32'(bus.row_done), 0);
    chk("mrst_cnt", 32'(bus.row_cnt), 0);
    chk("mrst_avail", 32'(bus.rows_avail), 0);
    chk("mrst_ovf", 32'(bus.overflow), 0);
    chk("mrst_mj", 32'(bus.mj_ready), 0);
    rstb = 1'b1;
    tick;
    chk("mrel_mj", 32'(bus.mj_ready), 1);
    tick;
    chk("mrel_valid", 32'(bus.row_valid), 0);

    // 14 clusters, 12 stored
    for (int i = 0; i < 14; i++) exp_w[i] = cw(i, i % 16, i, i + 1);
    for (int i = 0; i < 12; i++) push(exp_w[i]);
    chk("full_ovf0", 32'(bus.overflow), 0);
    push(exp_w[12]);
    chk("full_ovf1", 32'(bus.overflow), 1);
    push(exp_w[13]);
    close_row;
    chk("full_avail", 32'(bus.rows_avail), 1);
    expect_row("full", 12, 78);
    chk("full_avail_end", 32'(bus.rows_avail), 0);
    chk("full_ovf_sticky", 32'(bus.overflow), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
